// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and the pipeline stage record for adder_pipe
package adder_pkg;
  localparam int ADDER_WIDTH = 32;
  localparam int ADDER_CHUNK = 8;
  localparam int MAX_WIDTH = 64;
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
  } stage_t;
endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit add with carry-in and carry-out
module adder_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: valid/ready pipelined adder/subtractor, one CHUNK of carry chain per stage
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / CHUNK;
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a multiple of CHUNK, CHUNK <= WIDTH <= MAX_WIDTH");
  end
  logic en;
  stage_t in_rec, last;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  always_comb begin
    in_rec = '0;
    in_rec.valid = in_valid;
    in_rec.a[WIDTH-1:0] = a;
    in_rec.b[WIDTH-1:0] = sub ? ~b : b;
    in_rec.carry = sub | cin;
  end
  for (genvar k = 0; k < N; k++) begin : g
    stage_t prv, nxt, r;
    logic [CHUNK-1:0] s;
    logic co;
    if (k == 0) begin : g_first
      assign prv = in_rec;
    end else begin : g_next
      assign prv = g[k-1].r;
    end
    adder_chunk #(.W(CHUNK)) u_chunk (
      .a (prv.a[k*CHUNK +: CHUNK]),
      .b (prv.b[k*CHUNK +: CHUNK]),
      .ci(prv.carry),
      .s (s),
      .co(co)
    );
    // the MSB's carry-in is recovered from its sum bit: a ^ b' ^ s
    always_comb begin
      nxt = prv;
      nxt.sum[k*CHUNK +: CHUNK] = s;
      nxt.carry = co;
      nxt.ovf = (k == N - 1) && (prv.a[WIDTH-1] ^ prv.b[WIDTH-1] ^ s[CHUNK-1] ^ co);
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) r <= '0;
      else if (en) r <= nxt;
  end
  assign last = g[N-1].r;
  assign out_valid = last.valid;
  assign sum = last.sum[WIDTH-1:0];
  assign cout = last.carry;
  assign ovf = last.ovf;
endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, giving bits added per pipeline stage; N = WIDTH/CHUNK stages.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand set is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in, used only when sub=0.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 selects a+b+cin; 1 selects a-b, computed as a+~b+1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-014 The block SHALL have port cout, output, 1 bit: carry-out of the MSB; when sub=1, 1 means no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow of the full WIDTH operation.

Function
REQ-016 A transfer SHALL occur on an input when in_valid&&in_ready, and on an output when out_valid&&out_ready.
REQ-017 Global advance enable: en = !out_valid || out_ready; in_ready SHALL equal en, combinationally.
REQ-018 When en=0, every stage register SHALL hold its value, and sum/cout/ovf SHALL stay stable while out_valid=1.
REQ-019 Stage k (0..N-1) SHALL add chunk k of a and b' (b' = sub ? ~b : b) plus the carry registered by stage k-1; stage 0 uses sub ? 1 : cin.
REQ-020 Operand chunks above k SHALL be delayed alongside the stage; result chunks below k SHALL be carried forward unmodified.
REQ-021 Latency SHALL be exactly N cycles from an accepted input to out_valid, with no stall; throughput SHALL be one result per cycle.
REQ-022 Each stage SHALL carry a valid bit; an input cycle without a transfer SHALL insert a bubble that propagates in order.
REQ-023 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-024 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB, registered in the final stage.
REQ-025 WIDTH%CHUNK != 0 or CHUNK > WIDTH SHALL be an elaboration error; CHUNK == WIDTH SHALL give latency 1.

Reset
REQ-026 While rst=1, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0, asynchronously.
REQ-027 Transactions in flight at reset assertion SHALL be discarded; no stale result SHALL appear after release.
REQ-028 in_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-029 Shared package adder_pkg SHALL hold default WIDTH and CHUNK constants and the stage-record typedef (valid, partial sum, pending operands, carry).
REQ-030 One sub-module, adder_chunk, SHALL be instantiated N times: a combinational CHUNK-bit add with carry-in and carry-out.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-031 a=0xFFFFFFFF, b=1, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0; out_valid exactly 4 cycles after accept.
REQ-032 a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-033 sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0; sub=1, a=7, b=5 -> sum=2, cout=1, ovf=0.
REQ-034 8 back-to-back inputs, out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall; all 8 results in order, none lost or duplicated.
REQ-035 rst pulsed with 3 transactions in flight -> out_valid=0 immediately; no output until new inputs; the next input yields a correct result after 4 cycles.
REQ-036 CHUNK=32: a=0x000000FF, b=1 -> sum=0x00000100, latency 1; CHUNK=4: latency 8, carry propagates across all chunks.
